// File: rtl/rv32_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback,
// runs the imem/dmem request-ack handshakes with a bus watchdog, and counts retirements.
module rv32_multicycle_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [4:0]       rd,
  input  logic             branch_taken,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             ir_we,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             alu_en,
  output logic             alu_src_imm,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             halted,
  output logic             illegal,
  output logic             bus_err,
  output logic [2:0]       dbg_state
);

  // Handshakes: a request stays high for every cycle the FSM waits in FETCH/MEM;
  // the matching ack completes the transfer in the cycle it is sampled high,
  // including the very first request cycle. Acks in any other state are ignored.

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_TRAP   = 3'd7
  } state_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam int              WAIT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);
  localparam bit              WDOG_EN  = (TIMEOUT != 0);

  state_e            state_q, state_d;
  logic [6:0]        op_q, op_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  instret_q, instret_d;
  logic              illegal_q, illegal_d;
  logic              bus_err_q, bus_err_d;

  // funct3 is part of the decoder bundle but no control decision depends on it.
  logic funct3_unused;
  assign funct3_unused = ^funct3;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    wait_d      = wait_q;
    illegal_d   = illegal_q;
    bus_err_d   = bus_err_q;
    imem_req    = 1'b0;
    ir_we       = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    reg_we      = 1'b0;
    wb_sel      = 2'd0;
    alu_en      = 1'b0;
    alu_src_imm = 1'b0;
    pc_we       = 1'b0;
    pc_src      = 2'd0;
    retire      = 1'b0;
    halted      = 1'b0;

    case (state_q)
      S_RESET: begin
        state_d = S_FETCH;
        wait_d  = '0;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
          wait_d  = '0;
        end else if (WDOG_EN) begin
          if (wait_q == WAIT_MAX) begin
            state_d   = S_TRAP;
            bus_err_d = 1'b1;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
      end
      S_DECODE: begin
        op_d = opcode;
        case (opcode)
          OPC_LOAD, OPC_STORE, OPC_OP, OPC_OPIMM, OPC_BRANCH,
          OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: state_d = S_EXEC;
          OPC_SYSTEM: state_d = S_HALT;
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_EXEC: begin
        alu_en      = 1'b1;
        alu_src_imm = !((op_q == OPC_OP) || (op_q == OPC_BRANCH));
        if (op_q == OPC_BRANCH) begin
          pc_we   = 1'b1;
          pc_src  = branch_taken ? 2'd1 : 2'd0;
          retire  = 1'b1;
          state_d = S_FETCH;
          wait_d  = '0;
        end else if ((op_q == OPC_LOAD) || (op_q == OPC_STORE)) begin
          state_d = S_MEM;
          wait_d  = '0;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (op_q == OPC_STORE);
        if (dmem_ack) begin
          wait_d = '0;
          if (op_q == OPC_STORE) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (WDOG_EN) begin
          if (wait_q == WAIT_MAX) begin
            state_d   = S_TRAP;
            bus_err_d = 1'b1;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
      end
      S_WB: begin
        reg_we = (rd != 5'd0);
        if (op_q == OPC_LOAD) begin
          wb_sel = 2'd1;
        end else if ((op_q == OPC_JAL) || (op_q == OPC_JALR)) begin
          wb_sel = 2'd2;
        end
        pc_we = 1'b1;
        if (op_q == OPC_JAL) begin
          pc_src = 2'd2;
        end else if (op_q == OPC_JALR) begin
          pc_src = 2'd3;
        end
        retire  = 1'b1;
        state_d = S_FETCH;
        wait_d  = '0;
      end
      S_HALT: halted = 1'b1;
      S_TRAP: ;
      default: state_d = S_RESET;
    endcase

    instret_d = instret_q + CNT_W'(retire);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RESET;
      op_q      <= '0;
      wait_q    <= '0;
      instret_q <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign instret   = instret_q;
  assign illegal   = illegal_q;
  assign bus_err   = bus_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rv32_multicycle_ctrl.sv
// Directed bench for rv32_multicycle_ctrl: a driver issues instructions and queues the
// expected retirement record; a monitor pops and compares on every retire pulse.
module tb_rv32_multicycle_ctrl;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 4;
  localparam int W       = 22;

  logic             clk;
  logic             rst_n;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [4:0]       rd;
  logic             branch_taken;
  logic             imem_req;
  logic             imem_ack;
  logic             ir_we;
  logic             dmem_req;
  logic             dmem_we;
  logic             dmem_ack;
  logic             reg_we;
  logic [1:0]       wb_sel;
  logic             alu_en;
  logic             alu_src_imm;
  logic             pc_we;
  logic [1:0]       pc_src;
  logic             retire;
  logic [CNT_W-1:0] instret;
  logic             halted;
  logic             illegal;
  logic             bus_err;
  logic [2:0]       dbg_state;

  rv32_multicycle_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .rd(rd),
    .branch_taken(branch_taken), .imem_req(imem_req), .imem_ack(imem_ack),
    .ir_we(ir_we), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .reg_we(reg_we), .wb_sel(wb_sel), .alu_en(alu_en), .alu_src_imm(alu_src_imm),
    .pc_we(pc_we), .pc_src(pc_src), .retire(retire), .instret(instret),
    .halted(halted), .illegal(illegal), .bus_err(bus_err), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: got still running, expected finished");
    $fatal(1, "simulation time limit");
  end

  int n_vec   = 0;
  int n_err   = 0;
  int ret_cnt = 0;
  // record: {cycles[21:16], mem_cyc[15:12], mem_we[11], alu_imm[10], pc_we[9],
  //          pc_src[8:7], reg_we[6], wb_sel[5:4], instret_before[3:0]}
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input int cyc, input int mc, input bit mwe, input bit aimm,
                                      input int pcs, input bit rwe, input int wbs, input int ir);
    return {6'(cyc), 4'(mc), mwe, aimm, 1'b1, 2'(pcs), rwe, 2'(wbs), 4'(ir)};
  endfunction

  task automatic check_idle(input string name);
    check({name, "_outputs"}, 32'({imem_req, ir_we, dmem_req, dmem_we, reg_we, wb_sel, alu_en,
                                   alu_src_imm, pc_we, pc_src, retire, halted, illegal, bus_err}), 32'd0);
    check({name, "_instret"}, 32'(instret), 32'd0);
    check({name, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    rst_n    = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    #2;
    check_idle(name);
    ret_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // driver: waits for the fetch, presents decoder fields, then acks after iw/dw wait cycles
  task automatic run(input logic [31:0] instr, input int iw, input int dw, input bit taken,
                     input bit want, input int e_cyc, input int e_mc, input bit e_we,
                     input bit e_aimm, input int e_pcs, input bit e_rwe, input int e_wbs);
    int k;
    k = 0;
    while (imem_req !== 1'b1 && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= 50) begin
      check("imem_req_wait", 32'd0, 32'd1);
      return;
    end
    opcode       = instr[6:0];
    rd           = instr[11:7];
    funct3       = instr[14:12];
    branch_taken = taken;
    if (want) begin
      exp_q.push_back(mk(e_cyc, e_mc, e_we, e_aimm, e_pcs, e_rwe, e_wbs, ret_cnt));
      ret_cnt++;
    end
    repeat (iw) begin
      @(posedge clk);
      #1;
    end
    imem_ack = 1'b1;
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    if (e_mc > 0) begin
      k = 0;
      while (dmem_req !== 1'b1 && k < 50) begin
        @(posedge clk);
        #1;
        k++;
      end
      if (k >= 50) begin
        check("dmem_req_wait", 32'd0, 32'd1);
        return;
      end
      repeat (dw) begin
        @(posedge clk);
        #1;
      end
      dmem_ack = 1'b1;
      @(posedge clk);
      #1;
      dmem_ack = 1'b0;
    end
  endtask

  // monitor / scoreboard
  initial begin : monitor
    int cyc;
    int start_cyc;
    int mem_cyc;
    logic we_seen;
    logic imm_seen;
    logic prev_req;
    logic pend;
    logic [3:0] pend_val;
    logic [W-1:0] e;
    cyc = 0; start_cyc = 0; mem_cyc = 0;
    we_seen = 1'b0; imm_seen = 1'b0; prev_req = 1'b0; pend = 1'b0; pend_val = 4'd0;
    forever begin
      @(negedge clk);
      cyc++;
      if (pend) begin
        check("instret_after", 32'(instret), 32'(pend_val));
        pend = 1'b0;
      end
      if (imem_req && !prev_req) begin
        start_cyc = cyc;
        mem_cyc   = 0;
        we_seen   = 1'b0;
        imm_seen  = 1'b0;
      end
      prev_req = imem_req;
      if (dmem_req) begin
        mem_cyc++;
        we_seen |= dmem_we;
      end
      if (alu_en) imm_seen = alu_src_imm;
      if (retire) begin
        if (exp_q.size() == 0) begin
          check("unexpected_retire", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("cycles", 32'(cyc - start_cyc + 1), 32'(e[21:16]));
          check("dmem_req_cycles", 32'(mem_cyc), 32'(e[15:12]));
          check("dmem_we", 32'(we_seen), 32'(e[11]));
          check("alu_src_imm", 32'(imm_seen), 32'(e[10]));
          check("pc_we", 32'(pc_we), 32'(e[9]));
          check("pc_src", 32'(pc_src), 32'(e[8:7]));
          check("reg_we", 32'(reg_we), 32'(e[6]));
          check("wb_sel", 32'(wb_sel), 32'(e[5:4]));
          check("instret_before", 32'(instret), 32'(e[3:0]));
          pend     = 1'b1;
          pend_val = e[3:0] + 4'd1;
        end
      end
    end
  end

  initial begin : stim
    int k;
    rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    opcode = 7'd0; funct3 = 3'd0; rd = 5'd0; branch_taken = 1'b0;
    #12;
    check_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;

    //   instr          iw dw tk want cyc mc we imm pcs rwe wbs
    run(32'h002081B3, 0, 0, 0, 1,   4,  0, 0, 0,  0,  1,  0);  // ADD x3,x1,x2
    run(32'h0000A283, 0, 3, 0, 1,   8,  4, 0, 1,  0,  1,  1);  // LW x5,0(x1)
    run(32'h00208463, 0, 0, 1, 1,   3,  0, 0, 0,  1,  0,  0);  // BEQ taken
    run(32'h00208463, 0, 0, 0, 1,   3,  0, 0, 0,  0,  0,  0);  // BEQ not taken
    run(32'h00100013, 0, 0, 0, 1,   4,  0, 0, 1,  0,  0,  0);  // ADDI x0,x0,1
    run(32'h0020A223, 2, 0, 0, 1,   6,  1, 1, 1,  0,  0,  0);  // SW x2,4(x1)
    run(32'h008000EF, 0, 0, 0, 1,   4,  0, 0, 1,  2,  1,  2);  // JAL x1
    run(32'h00008067, 1, 0, 0, 1,   5,  0, 0, 1,  3,  0,  2);  // JALR x0,0(x1)
    run(32'h123453B7, 0, 0, 0, 1,   4,  0, 0, 1,  0,  1,  0);  // LUI x7
    run(32'h00001417, 0, 0, 0, 1,   4,  0, 0, 1,  0,  1,  0);  // AUIPC x8
    // retires 11..17: instret walks 10..15 then wraps to 0
    for (int i = 0; i < 7; i++) begin
      run(32'h002081B3, 0, 0, 0, 1, 4, 0, 0, 0, 0, 1, 0);
    end

    run(32'h0000007F, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (100) @(posedge clk);
    #1;
    check("trap_illegal", 32'(illegal), 32'd1);
    check("trap_state", 32'(dbg_state), 32'd7);
    check("trap_halted", 32'(halted), 32'd0);
    check("trap_imem_req", 32'(imem_req), 32'd0);
    do_reset("after_trap");

    run(32'h00000073, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (100) @(posedge clk);
    #1;
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_state", 32'(dbg_state), 32'd6);
    check("halt_illegal", 32'(illegal), 32'd0);
    do_reset("after_halt");

    // ack lands in the last allowed request cycle: no bus error
    run(32'h002081B3, 4, 0, 0, 1, 8, 0, 0, 0, 0, 1, 0);

    k = 0;
    while (imem_req !== 1'b1 && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("late_ack_no_bus_err", 32'(bus_err), 32'd0);
    k = 0;
    while (imem_req === 1'b1 && k < 50) begin
      k++;
      @(posedge clk);
      #1;
    end
    check("timeout_req_cycles", 32'(k), 32'd5);
    check("timeout_bus_err", 32'(bus_err), 32'd1);
    check("timeout_state", 32'(dbg_state), 32'd7);
    check("timeout_instret", 32'(instret), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("bus_err_sticky", 32'(bus_err), 32'd1);
    do_reset("after_timeout");

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
